// File: rtl/cpu_pkg.sv
// Shared core-debug definitions: regfile geometry and the dump-reader state encoding.
package cpu_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   typedef enum logic [2:0] {
      DUMP_IDLE   = 3'd0,
      DUMP_FETCH  = 3'd1,
      DUMP_DRAIN0 = 3'd2,
      DUMP_DRAIN1 = 3'd3,
      DUMP_FIN    = 3'd4
   } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Halted-core regfile dump: fetches two registers per pass over rs1/rs2 and streams {addr,data}.
// Outputs decode from state and hold regs, so a stalled beat stays stable until accepted.
module regfile_dump_reader
   import cpu_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int DATA_W   = REG_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic [ADDR_W-1:0] rs1_addr,
   output logic [ADDR_W-1:0] rs2_addr,
   input  logic [DATA_W-1:0] rs1_data,
   input  logic [DATA_W-1:0] rs2_data,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] checksum
);

   localparam logic [ADDR_W:0] REG_END = (ADDR_W+1)'(NUM_REGS);

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [DATA_W-1:0] hold0_q, hold0_d;
   logic [DATA_W-1:0] hold1_q, hold1_d;
   logic              hold1_vld_q, hold1_vld_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] csum_q, csum_d;

   // ptr+1 carries an extra bit so the top register never aliases to 0
   logic [ADDR_W:0]   ptr_inc;
   logic              at_last;
   logic              inc_last;
   logic              accept;

   assign ptr_inc  = {1'b0, ptr_q} + {{ADDR_W{1'b0}}, 1'b1};
   assign at_last  = (ptr_q == last_q);
   assign inc_last = (ptr_inc == {1'b0, last_q});
   assign accept   = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DUMP_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DUMP_IDLE: begin
            if (start) begin
               state_d = (first_addr > last_addr) ? DUMP_FIN : DUMP_FETCH;
            end
         end
         DUMP_FETCH: state_d = DUMP_DRAIN0;
         DUMP_DRAIN0: begin
            if (accept) begin
               state_d = (at_last || !hold1_vld_q) ? DUMP_FIN : DUMP_DRAIN1;
            end
         end
         DUMP_DRAIN1: begin
            if (accept) begin
               state_d = inc_last ? DUMP_FIN : DUMP_FETCH;
            end
         end
         DUMP_FIN: state_d = DUMP_IDLE;
         default:  state_d = DUMP_IDLE;
      endcase
   end

   always_comb begin
      rs1_addr  = '0;
      rs2_addr  = '0;
      busy      = 1'b0;
      out_valid = 1'b0;
      out_addr  = '0;
      out_data  = '0;
      out_last  = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state_q)
         DUMP_FETCH: begin
            busy     = 1'b1;
            rs1_addr = ptr_q;
            rs2_addr = at_last ? ptr_q : ptr_inc[ADDR_W-1:0];
         end
         DUMP_DRAIN0: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_addr  = ptr_q;
            out_data  = hold0_q;
            out_last  = at_last;
         end
         DUMP_DRAIN1: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_addr  = ptr_inc[ADDR_W-1:0];
            out_data  = hold1_q;
            out_last  = inc_last;
         end
         DUMP_FIN: begin
            done = 1'b1;
            err  = err_q;
         end
         default: ;
      endcase
   end

   assign checksum = csum_q;

   always_comb begin
      ptr_d       = ptr_q;
      last_d      = last_q;
      hold0_d     = hold0_q;
      hold1_d     = hold1_q;
      hold1_vld_d = hold1_vld_q;
      err_d       = err_q;
      csum_d      = csum_q;
      case (state_q)
         DUMP_IDLE: begin
            if (start) begin
               ptr_d  = first_addr;
               last_d = last_addr;
               err_d  = (first_addr > last_addr);
               csum_d = '0;
            end
         end
         DUMP_FETCH: begin
            hold0_d     = rs1_data;
            hold1_d     = rs2_data;
            hold1_vld_d = !at_last && (ptr_inc < REG_END);
         end
         DUMP_DRAIN0: begin
            if (accept) begin
               csum_d = csum_q + hold0_q;
            end
         end
         DUMP_DRAIN1: begin
            if (accept) begin
               csum_d = csum_q + hold1_q;
               if (!inc_last) begin
                  ptr_d = ptr_q + ADDR_W'(2);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q       <= '0;
         last_q      <= '0;
         hold0_q     <= '0;
         hold1_q     <= '0;
         hold1_vld_q <= 1'b0;
         err_q       <= 1'b0;
         csum_q      <= '0;
      end else begin
         ptr_q       <= ptr_d;
         last_q      <= last_d;
         hold0_q     <= hold0_d;
         hold1_q     <= hold1_d;
         hold1_vld_q <= hold1_vld_d;
         err_q       <= err_d;
         csum_q      <= csum_d;
      end
   end

endmodule
